pingpong_nbank_channel: RTL and testbench
=========================================

Name: pingpong_nbank_channel

Overview:
- Multi-bank ping-pong channel memory between one producer and one consumer process in a dataflow top.
- Generalises the fixed two-bank channel: parametrised data width, words per bank and bank count (N-buffering), plus optional sticky protocol-error flags.
- Producer fills its current bank through a RAM port and commits it with i_write. The consumer reads the oldest committed bank through its own RAM port and releases it with t_read.

Parameters:
DATA_WIDTH, 32, bits per word
DEPTH, 5, words per bank (>=1)
ADDR_WIDTH, 3, per-bank address width, clog2(DEPTH) minimum
NUM_BANKS, 2, number of banks (>=2)

Ports:
ap_clk  in  1  clock, all state on rising edge
ap_rst_n  in  1  asynchronous active-low reset
i_address0  in  ADDR_WIDTH  producer word address within producer bank
i_ce0  in  1  producer port enable
i_we0  in  1  producer write enable (qualified by i_ce0)
i_d0  in  DATA_WIDTH  producer write data
i_q0  out  DATA_WIDTH  producer read data
t_address0  in  ADDR_WIDTH  consumer word address within consumer bank
t_ce0  in  1  consumer port enable
t_we0  in  1  consumer write enable (qualified by t_ce0)
t_d0  in  DATA_WIDTH  consumer write data
t_q0  out  DATA_WIDTH  consumer read data
i_write  in  1  producer commits current bank
i_full_n  out  1  at least one free bank
t_read  in  1  consumer releases current bank
t_empty_n  out  1  at least one committed bank
count  out  clog2(NUM_BANKS+1)  committed banks
err  out  2  sticky errors: [0] write-while-full, [1] read-while-empty

Behaviour:
- Reset is asynchronous and active-low (ap_rst_n). Clock is ap_clk, single domain.
- Reset values: iptr=0, tptr=0, count=0, i_full_n=1, t_empty_n=0, i_q0=0, t_q0=0, err=0. Memory contents are not cleared.
- Storage is NUM_BANKS*DEPTH words. Physical address = bank*DEPTH + address0. The producer side uses bank iptr; the consumer side uses bank tptr.
- Write: when ce0&we0 and address0<DEPTH, the word is written at the clock edge.
- Read: when ce0 (with or without we0), q0 is registered with 1-cycle latency and holds its value while ce0=0.
- Read-first: a read of an address written in the same cycle, by either port, returns the old data.
- Both ports writing the same physical address in the same cycle: the producer write wins.
- address0>=DEPTH: the write is dropped and a read returns 0.
- Flags are combinational from registered state:
  - i_full_n = (count!=NUM_BANKS)
  - t_empty_n = (count!=0)
- Commit: i_write accepted only when i_full_n=1. On accept, iptr advances with wrap NUM_BANKS-1 -> 0 and count increments.
- Release: t_read accepted only when t_empty_n=1. On accept, tptr advances with the same wrap and count decrements.
- Simultaneous accepted i_write and t_read: both pointers advance and count is unchanged.
- When full, i_write is ignored even if t_read occurs in the same cycle. When empty, t_read is ignored even if i_write occurs in the same cycle.
- Ignored handshakes change no state other than err.
- Reset asserted mid-operation: all state returns to reset values immediately. Committed data is logically discarded.

Optional Feature:
- Macro PPBUF_PROTOCOL_ERR_EN.
- Defined: err[0] sets on i_write while i_full_n=0, and err[1] sets on t_read while t_empty_n=0. Both bits are sticky until reset.
- Undefined: err is tied to 2'b00 and no error logic is built.
- Handshake behaviour is identical in both builds.

Test Plan:
- Reset, NUM_BANKS=2, DEPTH=5: write bank0 words 0..4 = 10..14, pulse i_write -> count=1, t_empty_n=1; consumer reads addr 0..4 -> t_q0=10..14, each one cycle after its ce0.
- NUM_BANKS=3: three commits without t_read -> i_full_n=0, count=3; a fourth i_write is ignored (count stays 3, err[0]=1 with macro, 0 without); one t_read -> i_full_n=1.
- Count=1, simultaneous i_write and t_read -> count stays 1, iptr and tptr each advance by 1.
- Wrap: NUM_BANKS=2, five commit/release rounds with data pattern round*16+addr -> consumer reads match each round's pattern; bank index wraps 1 -> 0.
- Empty, t_read alone -> count stays 0 and err[1]=1 with macro; then assert ap_rst_n=0 mid-fill, asynchronously, without a clock edge -> count=0, i_full_n=1, t_empty_n=0, err=0.
- Producer writes 99 to address 2 while reading it in the same cycle -> i_q0 returns the old value. A write to address 5 (DEPTH=5) is dropped and a read of address 5 returns 0.

Source files
------------

// File: rtl/pingpong_nbank_channel.sv
// pingpong_nbank_channel
//   N-bank ping-pong channel memory between one producer and one consumer.
//   The producer fills bank iptr through its RAM port and commits it with
//   i_write; the consumer reads the oldest committed bank (tptr) through its
//   own RAM port and releases it with t_read.
//
// Ports:
//   ap_clk, ap_rst_n         clock, asynchronous active-low reset
//   i_address0/ce0/we0/d0    producer RAM port, i_q0 registered read data
//   t_address0/ce0/we0/d0    consumer RAM port, t_q0 registered read data
//   i_write / i_full_n       producer commit / at least one free bank
//   t_read  / t_empty_n      consumer release / at least one committed bank
//   count                    number of committed banks
//   err                      sticky errors [0] write-while-full,
//                            [1] read-while-empty
//
// Build option:
//   PPBUF_PROTOCOL_ERR_EN    when defined, err carries sticky protocol-error
//                            flags; otherwise err is tied to 2'b00.

module pingpong_nbank_channel #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 5,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned NUM_BANKS  = 2
) (
    input  logic                               ap_clk,
    input  logic                               ap_rst_n,
    input  logic [ADDR_WIDTH-1:0]              i_address0,
    input  logic                               i_ce0,
    input  logic                               i_we0,
    input  logic [DATA_WIDTH-1:0]              i_d0,
    output logic [DATA_WIDTH-1:0]              i_q0,
    input  logic [ADDR_WIDTH-1:0]              t_address0,
    input  logic                               t_ce0,
    input  logic                               t_we0,
    input  logic [DATA_WIDTH-1:0]              t_d0,
    output logic [DATA_WIDTH-1:0]              t_q0,
    input  logic                               i_write,
    output logic                               i_full_n,
    input  logic                               t_read,
    output logic                               t_empty_n,
    output logic [$clog2(NUM_BANKS+1)-1:0]     count,
    output logic [1:0]                         err
);

    localparam int unsigned BANK_W  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int unsigned CNT_W   = $clog2(NUM_BANKS + 1);
    localparam int unsigned WORDS   = NUM_BANKS * DEPTH;
    localparam int unsigned PADDR_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned AW1     = ADDR_WIDTH + 1;

    localparam logic [AW1-1:0]    DEPTH_LIM = AW1'(DEPTH);
    localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(NUM_BANKS);

    logic [DATA_WIDTH-1:0] mem [WORDS];

    logic [BANK_W-1:0]  iptr, iptr_nxt;
    logic [BANK_W-1:0]  tptr, tptr_nxt;
    logic [CNT_W-1:0]   count_nxt;

    logic               i_in_range, t_in_range;
    logic [PADDR_W-1:0] i_paddr, t_paddr;
    logic               i_wen, t_wen;
    logic               wr_acc, rd_acc;

    // Physical addressing: bank*DEPTH + word, out-of-range words are masked
    assign i_in_range = ({1'b0, i_address0} < DEPTH_LIM);
    assign t_in_range = ({1'b0, t_address0} < DEPTH_LIM);
    assign i_paddr    = PADDR_W'(iptr) * PADDR_W'(DEPTH) + PADDR_W'(i_address0);
    assign t_paddr    = PADDR_W'(tptr) * PADDR_W'(DEPTH) + PADDR_W'(t_address0);
    assign i_wen      = i_ce0 & i_we0 & i_in_range;
    assign t_wen      = t_ce0 & t_we0 & t_in_range;

    // Occupancy flags straight from the registered count
    assign i_full_n  = (count != FULL_CNT);
    assign t_empty_n = (count != '0);
    assign wr_acc    = i_write & i_full_n;
    assign rd_acc    = t_read & t_empty_n;

    // Storage; producer write is issued last so it wins a same-address clash
    always_ff @(posedge ap_clk) begin
        if (t_wen) mem[t_paddr] <= t_d0;
        if (i_wen) mem[i_paddr] <= i_d0;
    end

    // Registered read-first ports; q0 holds while ce0 is low
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            i_q0 <= '0;
            t_q0 <= '0;
        end else begin
            if (i_ce0) i_q0 <= i_in_range ? mem[i_paddr] : '0;
            if (t_ce0) t_q0 <= t_in_range ? mem[t_paddr] : '0;
        end
    end

    // Next-state for bank pointers and committed-bank count
    always_comb begin
        iptr_nxt  = iptr;
        tptr_nxt  = tptr;
        count_nxt = count;
        if (wr_acc) iptr_nxt = (iptr == LAST_BANK) ? '0 : iptr + BANK_W'(1);
        if (rd_acc) tptr_nxt = (tptr == LAST_BANK) ? '0 : tptr + BANK_W'(1);
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // Handshake state register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            iptr  <= '0;
            tptr  <= '0;
            count <= '0;
        end else begin
            iptr  <= iptr_nxt;
            tptr  <= tptr_nxt;
            count <= count_nxt;
        end
    end

`ifdef PPBUF_PROTOCOL_ERR_EN
    logic [1:0] err_nxt;

    // Sticky protocol errors, cleared only by reset
    always_comb begin
        err_nxt = err | {t_read & ~t_empty_n, i_write & ~i_full_n};
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) err <= 2'b00;
        else           err <= err_nxt;
    end
`else
    assign err = 2'b00;
`endif

endmodule

// File: tb/tb_pingpong_nbank_channel.sv
// Bench for pingpong_nbank_channel: two instances (2 banks and 3 banks,
// DEPTH=5, DATA_WIDTH=32) driven by directed vectors, checked every cycle
// against a bank/word model plus hand-computed literal expectations.

module tb_pingpong_nbank_channel;

`ifdef PPBUF_PROTOCOL_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        check_en;

    logic [2:0]  i_addr [2];
    logic [2:0]  t_addr [2];
    logic        i_ce [2], i_we [2], t_ce [2], t_we [2], i_wr [2], t_rd [2];
    logic [31:0] i_d [2], t_d [2], i_q [2], t_q [2];
    logic        full_n_o [2], empty_n_o [2];
    logic [1:0]  cnt_o [2], err_o [2];

    int checks = 0;
    int errors = 0;

    pingpong_nbank_channel #(.DATA_WIDTH(32), .DEPTH(5), .ADDR_WIDTH(3), .NUM_BANKS(2)) u_dut2 (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .i_address0(i_addr[0]), .i_ce0(i_ce[0]), .i_we0(i_we[0]), .i_d0(i_d[0]), .i_q0(i_q[0]),
        .t_address0(t_addr[0]), .t_ce0(t_ce[0]), .t_we0(t_we[0]), .t_d0(t_d[0]), .t_q0(t_q[0]),
        .i_write(i_wr[0]), .i_full_n(full_n_o[0]), .t_read(t_rd[0]), .t_empty_n(empty_n_o[0]),
        .count(cnt_o[0]), .err(err_o[0])
    );

    pingpong_nbank_channel #(.DATA_WIDTH(32), .DEPTH(5), .ADDR_WIDTH(3), .NUM_BANKS(3)) u_dut3 (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .i_address0(i_addr[1]), .i_ce0(i_ce[1]), .i_we0(i_we[1]), .i_d0(i_d[1]), .i_q0(i_q[1]),
        .t_address0(t_addr[1]), .t_ce0(t_ce[1]), .t_we0(t_we[1]), .t_d0(t_d[1]), .t_q0(t_q[1]),
        .i_write(i_wr[1]), .i_full_n(full_n_o[1]), .t_read(t_rd[1]), .t_empty_n(empty_n_o[1]),
        .count(cnt_o[1]), .err(err_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nb(input int k);
        return (k == 0) ? 2 : 3;
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (banks=%0d) t=%0t: got %0h expected %0h", name, nb(k), $time, act, exp);
        end
    endtask

    // Model: banks as arrays of words, committed banks tracked by
    // producer/consumer bank indices and an occupancy number.
    int          mi [2], mt [2], mc [2];
    logic [1:0]  me [2];
    logic [31:0] md [2][15];
    bit          mv [2][15];
    logic [31:0] eiq [2], etq [2];
    bit          eiqv [2], etqv [2];

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                mi[k] = 0; mt[k] = 0; mc[k] = 0; me[k] = 2'b00;
                eiq[k] = 0; etq[k] = 0; eiqv[k] = 1; etqv[k] = 1;
            end else begin
                int  ip, tp;
                bit  aw, ar;
                ip = mi[k] * 5 + int'(i_addr[k]);
                tp = mt[k] * 5 + int'(t_addr[k]);
                if (i_ce[k]) begin
                    if (i_addr[k] < 3'd5) begin eiq[k] = md[k][ip]; eiqv[k] = mv[k][ip]; end
                    else begin eiq[k] = 0; eiqv[k] = 1; end
                end
                if (t_ce[k]) begin
                    if (t_addr[k] < 3'd5) begin etq[k] = md[k][tp]; etqv[k] = mv[k][tp]; end
                    else begin etq[k] = 0; etqv[k] = 1; end
                end
                if (t_ce[k] && t_we[k] && t_addr[k] < 3'd5) begin md[k][tp] = t_d[k]; mv[k][tp] = 1; end
                if (i_ce[k] && i_we[k] && i_addr[k] < 3'd5) begin md[k][ip] = i_d[k]; mv[k][ip] = 1; end
                aw = i_wr[k] && (mc[k] < nb(k));
                ar = t_rd[k] && (mc[k] > 0);
                if (ERR_EN && i_wr[k] && mc[k] == nb(k)) me[k][0] = 1'b1;
                if (ERR_EN && t_rd[k] && mc[k] == 0)     me[k][1] = 1'b1;
                if (aw) mi[k] = (mi[k] + 1) % nb(k);
                if (ar) mt[k] = (mt[k] + 1) % nb(k);
                mc[k] = mc[k] + int'(aw) - int'(ar);
            end
        end
    end

    // Per-cycle comparison against the model, mid-cycle
    always @(negedge clk) begin
        if (check_en) begin
            for (int k = 0; k < 2; k++) begin
                chk("count", k, 32'(cnt_o[k]), 32'(mc[k]));
                chk("i_full_n", k, 32'(full_n_o[k]), 32'(mc[k] != nb(k)));
                chk("t_empty_n", k, 32'(empty_n_o[k]), 32'(mc[k] != 0));
                chk("err", k, 32'(err_o[k]), 32'(me[k]));
                if (eiqv[k]) chk("i_q0", k, i_q[k], eiq[k]);
                if (etqv[k]) chk("t_q0", k, t_q[k], etq[k]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        for (int k = 0; k < 2; k++) begin
            i_addr[k] = '0; t_addr[k] = '0; i_ce[k] = 0; i_we[k] = 0; t_ce[k] = 0; t_we[k] = 0;
            i_wr[k] = 0; t_rd[k] = 0; i_d[k] = '0; t_d[k] = '0;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk({tag, "_count"}, k, 32'(cnt_o[k]), 32'd0);
            chk({tag, "_full_n"}, k, 32'(full_n_o[k]), 32'd1);
            chk({tag, "_empty_n"}, k, 32'(empty_n_o[k]), 32'd0);
            chk({tag, "_err"}, k, 32'(err_o[k]), 32'd0);
            chk({tag, "_i_q0"}, k, i_q[k], 32'd0);
            chk({tag, "_t_q0"}, k, t_q[k], 32'd0);
        end
    endtask

    task automatic pwrite(input int k, input int a, input logic [31:0] d);
        i_addr[k] = 3'(a); i_ce[k] = 1; i_we[k] = 1; i_d[k] = d;
        tick();
        i_ce[k] = 0; i_we[k] = 0;
    endtask

    task automatic pulse_write(input int k);
        i_wr[k] = 1; tick(); i_wr[k] = 0;
    endtask

    task automatic pulse_read(input int k);
        t_rd[k] = 1; tick(); t_rd[k] = 0;
    endtask

    initial begin
        check_en = 0;
        rst_n = 0;
        idle();
        repeat (2) tick();
        chk_reset_vals("reset");
        rst_n = 1;
        check_en = 1;
        tick();

        // Fill bank 0 with 10..14, commit, read back through the consumer port
        for (int a = 0; a < 5; a++) pwrite(0, a, 32'(10 + a));
        pulse_write(0);
        chk("commit_count", 0, 32'(cnt_o[0]), 32'd1);
        chk("commit_empty_n", 0, 32'(empty_n_o[0]), 32'd1);
        for (int a = 0; a < 5; a++) begin
            t_addr[0] = 3'(a); t_ce[0] = 1;
            tick();
            chk("fill_t_q0", 0, t_q[0], 32'(10 + a));
        end
        t_ce[0] = 0;
        pulse_read(0);
        chk("release_count", 0, 32'(cnt_o[0]), 32'd0);

        // Three banks: fill to full, ignored write, release, full with both
        i_wr[1] = 1;
        repeat (3) tick();
        chk("full_count", 1, 32'(cnt_o[1]), 32'd3);
        chk("full_full_n", 1, 32'(full_n_o[1]), 32'd0);
        tick();
        i_wr[1] = 0;
        chk("over_count", 1, 32'(cnt_o[1]), 32'd3);
        chk("over_err0", 1, 32'(err_o[1][0]), 32'(ERR_EN));
        pulse_read(1);
        chk("after_rel_count", 1, 32'(cnt_o[1]), 32'd2);
        chk("after_rel_full_n", 1, 32'(full_n_o[1]), 32'd1);
        pulse_write(1);
        i_wr[1] = 1; t_rd[1] = 1;
        tick();
        i_wr[1] = 0;
        chk("full_both_count", 1, 32'(cnt_o[1]), 32'd2);
        repeat (2) tick();
        t_rd[1] = 0;
        chk("drain_count", 1, 32'(cnt_o[1]), 32'd0);
        i_wr[1] = 1; t_rd[1] = 1;
        tick();
        i_wr[1] = 0; t_rd[1] = 0;
        chk("empty_both_count", 1, 32'(cnt_o[1]), 32'd1);
        chk("empty_both_err1", 1, 32'(err_o[1][1]), 32'(ERR_EN));
        pulse_read(1);

        // Simultaneous commit/release at count=1: both banks advance
        pwrite(0, 0, 32'h100);
        pulse_write(0);
        pwrite(0, 0, 32'h200);
        i_wr[0] = 1; t_rd[0] = 1;
        tick();
        i_wr[0] = 0; t_rd[0] = 0;
        chk("simul_count", 0, 32'(cnt_o[0]), 32'd1);
        t_addr[0] = 0; t_ce[0] = 1; i_addr[0] = 0; i_ce[0] = 1;
        tick();
        t_ce[0] = 0; i_ce[0] = 0;
        chk("simul_tptr", 0, t_q[0], 32'h200);
        chk("simul_iptr", 0, i_q[0], 32'h100);
        pulse_read(0);

        // Five wrap rounds with pattern round*16+addr
        for (int r = 0; r < 5; r++) begin
            for (int a = 0; a < 5; a++) pwrite(0, a, 32'(r * 16 + a));
            pulse_write(0);
            for (int a = 0; a < 5; a++) begin
                t_addr[0] = 3'(a); t_ce[0] = 1;
                tick();
                chk("wrap_t_q0", 0, t_q[0], 32'(r * 16 + a));
            end
            t_ce[0] = 0;
            pulse_read(0);
        end

        // Both ports write the same word: producer wins
        i_addr[0] = 1; i_ce[0] = 1; i_we[0] = 1; i_d[0] = 32'hAA;
        t_addr[0] = 1; t_ce[0] = 1; t_we[0] = 1; t_d[0] = 32'hBB;
        tick();
        t_ce[0] = 0; t_we[0] = 0; i_we[0] = 0;
        tick();
        i_ce[0] = 0;
        chk("clash_prod_wins", 0, i_q[0], 32'hAA);

        // Read-first on the producer port
        pwrite(0, 2, 32'd7);
        pwrite(0, 2, 32'd99);
        chk("read_first_old", 0, i_q[0], 32'd7);
        i_addr[0] = 2; i_ce[0] = 1;
        tick();
        i_ce[0] = 0;
        chk("read_first_new", 0, i_q[0], 32'd99);

        // Out-of-range address: write dropped, read returns 0
        pwrite(0, 5, 32'd55);
        chk("oor_wr_q0", 0, i_q[0], 32'd0);
        i_addr[0] = 5; i_ce[0] = 1;
        tick();
        i_ce[0] = 0;
        chk("oor_rd_q0", 0, i_q[0], 32'd0);
        pulse_write(0);
        i_addr[0] = 0; i_ce[0] = 1;
        tick();
        i_ce[0] = 0;
        chk("oor_no_alias", 0, i_q[0], 32'd64);
        pulse_read(0);

        // Release while empty
        pulse_read(0);
        chk("empty_rd_count", 0, 32'(cnt_o[0]), 32'd0);
        chk("empty_rd_err1", 0, 32'(err_o[0][1]), 32'(ERR_EN));

        // Asynchronous reset mid-fill, checked before any clock edge
        pwrite(0, 0, 32'h33);
        pulse_write(0);
        i_addr[0] = 1; i_ce[0] = 1; i_we[0] = 1; i_d[0] = 32'h34;
        #2;
        rst_n = 0;
        #1;
        chk_reset_vals("async_rst");
        idle();
        repeat (2) tick();
        rst_n = 1;
        tick();

        // Channel works again after reset
        pwrite(0, 3, 32'h77);
        pulse_write(0);
        t_addr[0] = 3; t_ce[0] = 1;
        tick();
        t_ce[0] = 0;
        chk("post_rst_t_q0", 0, t_q[0], 32'h77);
        pulse_read(0);
        tick();

        check_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
